// File: rtl/sopc_mem_arbiter.sv
// Shares one synchronous memory port among NUM_M req/ack masters, with
// fixed-priority or round-robin arbitration and a configurable wait-state count.
module sopc_mem_arbiter #(
  parameter int NUM_M       = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1,
  parameter int PRIO_MODE   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_M-1:0]           m_req,
  input  logic [NUM_M-1:0]           m_we,
  input  logic [NUM_M*ADDR_W-1:0]    m_addr,
  input  logic [NUM_M*DATA_W-1:0]    m_wdata,
  input  logic [NUM_M*DATA_W/8-1:0]  m_sel,
  output logic [NUM_M-1:0]           m_ack,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       mem_ce,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_sel,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam logic [IDX_W:0] NUM_M_V = (IDX_W + 1)'(NUM_M);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t           state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] winner;
  logic [3:0]       cnt;
  logic [IDX_W:0]   rr_sum;

  // Round-robin walks downward so the candidate closest after last_grant wins.
  always_comb begin
    winner = '0;
    rr_sum = '0;
    if (PRIO_MODE == 0) begin
      for (int k = NUM_M - 1; k >= 0; k--)
        if (m_req[k]) winner = IDX_W'(k);
    end else begin
      for (int k = NUM_M; k >= 1; k--) begin
        rr_sum = {1'b0, last_grant} + (IDX_W + 1)'(k);
        if (rr_sum >= NUM_M_V) rr_sum = rr_sum - NUM_M_V;
        if (m_req[IDX_W'(rr_sum)]) winner = IDX_W'(rr_sum);
      end
    end
  end

  always_comb begin
    mem_ce    = (state == BUSY);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_sel   = '0;
    if (state == BUSY) begin
      for (int k = 0; k < NUM_M; k++) begin
        if (grant == IDX_W'(k)) begin
          mem_we    = m_we[k];
          mem_addr  = m_addr[k*ADDR_W +: ADDR_W];
          mem_wdata = m_wdata[k*DATA_W +: DATA_W];
          mem_sel   = m_sel[k*SEL_W +: SEL_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_M - 1);
      cnt        <= '0;
      m_ack      <= '0;
      m_rdata    <= '0;
    end else begin
      m_ack <= '0;
      case (state)
        IDLE: begin
          if (|m_req) begin
            grant      <= winner;
            last_grant <= winner;
            cnt        <= 4'(WAIT_STATES);
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            m_rdata      <= mem_we ? '0 : mem_rdata;
            m_ack[grant] <= 1'b1;
            state        <= ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Scoreboard bench: a 2-master fixed-priority arbiter (1 wait state) and a
// 4-master round-robin arbiter (0 wait states) against a simple memory model.
module tb_sopc_mem_arbiter;

  typedef struct {
    logic [7:0]  ack;
    logic [31:0] rdata;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  exp_t fp_q[$];
  exp_t rr_q[$];
  int   fp_cnt = 0, rr_cnt = 0;
  int   fp_last = 0, rr_last = 0;

  logic        rst_fp, rst_rr;
  logic [1:0]  fp_req, fp_we, fp_ack;
  logic [63:0] fp_addr, fp_wdata;
  logic [7:0]  fp_sel;
  logic [31:0] fp_rdata, fp_maddr, fp_mwdata, fp_mrdata;
  logic        fp_ce, fp_mwe;
  logic [3:0]  fp_msel;

  logic [3:0]   rr_req, rr_we, rr_ack;
  logic [127:0] rr_addr, rr_wdata;
  logic [15:0]  rr_sel;
  logic [31:0]  rr_rdata, rr_maddr, rr_mwdata, rr_mrdata;
  logic         rr_ce, rr_mwe;
  logic [3:0]   rr_msel;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h3C01ABDD;
  endfunction

  assign fp_mrdata = mem_fn(fp_maddr);
  assign rr_mrdata = mem_fn(rr_maddr);

  sopc_mem_arbiter #(.NUM_M(2), .ADDR_W(32), .DATA_W(32), .WAIT_STATES(1), .PRIO_MODE(0)) dut_fp (
    .clk(clk), .rst(rst_fp), .m_req(fp_req), .m_we(fp_we), .m_addr(fp_addr),
    .m_wdata(fp_wdata), .m_sel(fp_sel), .m_ack(fp_ack), .m_rdata(fp_rdata),
    .mem_ce(fp_ce), .mem_we(fp_mwe), .mem_addr(fp_maddr), .mem_wdata(fp_mwdata),
    .mem_sel(fp_msel), .mem_rdata(fp_mrdata)
  );

  sopc_mem_arbiter #(.NUM_M(4), .ADDR_W(32), .DATA_W(32), .WAIT_STATES(0), .PRIO_MODE(1)) dut_rr (
    .clk(clk), .rst(rst_rr), .m_req(rr_req), .m_we(rr_we), .m_addr(rr_addr),
    .m_wdata(rr_wdata), .m_sel(rr_sel), .m_ack(rr_ack), .m_rdata(rr_rdata),
    .mem_ce(rr_ce), .mem_we(rr_mwe), .mem_addr(rr_maddr), .mem_wdata(rr_mwdata),
    .mem_sel(rr_msel), .mem_rdata(rr_mrdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input bit to_rr, input logic [7:0] ack, input logic [31:0] rd, input int gap);
    exp_t e;
    e.ack = ack; e.rdata = rd; e.gap = gap;
    if (to_rr) rr_q.push_back(e);
    else fp_q.push_back(e);
  endtask

  task automatic wait_acks(input bit use_rr, input int target, input string tag);
    int n;
    n = 0;
    while (((use_rr ? rr_cnt : fp_cnt) < target) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 200), 64'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (fp_ack != '0) begin
      fp_cnt++;
      if (fp_q.size() == 0) chk("fp_unexpected_ack", 64'(fp_ack), 64'd0);
      else begin
        e = fp_q.pop_front();
        chk("fp_grant", 64'(fp_ack), 64'(e.ack));
        chk("fp_rdata", 64'(fp_rdata), 64'(e.rdata));
        if (e.gap != 0) chk("fp_gap", 64'(cyc - fp_last), 64'(e.gap));
      end
      fp_last = cyc;
    end
    if (rr_ack != '0) begin
      rr_cnt++;
      if (rr_q.size() == 0) chk("rr_unexpected_ack", 64'(rr_ack), 64'd0);
      else begin
        e = rr_q.pop_front();
        chk("rr_grant", 64'(rr_ack), 64'(e.ack));
        chk("rr_rdata", 64'(rr_rdata), 64'(e.rdata));
        if (e.gap != 0) chk("rr_gap", 64'(cyc - rr_last), 64'(e.gap));
      end
      rr_last = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_fp = 1'b1; rst_rr = 1'b1;
    fp_req = '0; fp_we = '0; fp_addr = '0; fp_wdata = '0; fp_sel = '0;
    rr_req = '0; rr_we = '0; rr_addr = '0; rr_wdata = '0; rr_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_fp_ack", 64'(fp_ack), 64'd0);
    chk("rst_fp_rdata", 64'(fp_rdata), 64'd0);
    chk("rst_fp_ce", 64'(fp_ce), 64'd0);
    chk("rst_fp_we", 64'(fp_mwe), 64'd0);
    chk("rst_fp_addr", 64'(fp_maddr), 64'd0);
    chk("rst_fp_wdata", 64'(fp_mwdata), 64'd0);
    chk("rst_fp_sel", 64'(fp_msel), 64'd0);
    chk("rst_rr_ack", 64'(rr_ack), 64'd0);
    chk("rst_rr_ce", 64'(rr_ce), 64'd0);
    rst_fp = 1'b0; rst_rr = 1'b0;
    @(negedge clk);

    // round-robin, zero wait states: lone request from master 3
    rr_addr[3*32 +: 32] = 32'h40;
    rr_req = 4'b1000;
    push(1'b1, 8'b1000, mem_fn(32'h40), 0);
    @(negedge clk);
    chk("rr_ws0_ce", 64'(rr_ce), 64'd1);
    chk("rr_ws0_addr", 64'(rr_maddr), 64'h40);
    @(negedge clk);
    chk("rr_ws0_lat", 64'(rr_ack), 64'b1000);
    chk("rr_ws0_ce_off", 64'(rr_ce), 64'd0);
    rr_req = '0;
    repeat (3) @(negedge clk);

    // all four requesting: rotation starts after master 3
    for (int i = 0; i < 4; i++) rr_addr[i*32 +: 32] = 32'h100 + 32'(i * 4);
    base = rr_cnt;
    for (int i = 0; i < 6; i++)
      push(1'b1, 8'(1 << (i % 4)), mem_fn(32'h100 + 32'((i % 4) * 4)), (i == 0) ? 0 : 3);
    rr_req = 4'b1111;
    wait_acks(1'b1, base + 6, "rr_all_wait");
    rr_req = '0;
    repeat (4) @(negedge clk);

    // masters 0 and 2 after last grant 1: 2 first, then wrap to 0
    base = rr_cnt;
    push(1'b1, 8'b0100, mem_fn(32'h108), 0);
    push(1'b1, 8'b0001, mem_fn(32'h100), 3);
    rr_req = 4'b0101;
    wait_acks(1'b1, base + 2, "rr_wrap_wait");
    rr_req = '0;
    repeat (4) @(negedge clk);
    chk("rr_queue_empty", 64'(rr_q.size()), 64'd0);

    // fixed priority: single read by master 0
    fp_addr[31:0] = 32'h10;
    fp_req = 2'b01;
    push(1'b0, 8'b01, 32'h3C01ABCD, 0);
    @(negedge clk);
    chk("fp_rd_ce1", 64'(fp_ce), 64'd1);
    chk("fp_rd_addr", 64'(fp_maddr), 64'h10);
    chk("fp_rd_we", 64'(fp_mwe), 64'd0);
    @(negedge clk);
    chk("fp_rd_ce2", 64'(fp_ce), 64'd1);
    @(negedge clk);
    chk("fp_rd_lat", 64'(fp_ack), 64'b01);
    chk("fp_rd_ce_off", 64'(fp_ce), 64'd0);
    fp_req = '0;
    @(negedge clk);
    chk("fp_idle_addr", 64'(fp_maddr), 64'd0);

    // write with byte enables from master 1
    fp_addr[63:32] = 32'h20; fp_wdata[63:32] = 32'hDEADBEEF; fp_sel[7:4] = 4'b0011;
    fp_we = 2'b10; fp_req = 2'b10;
    push(1'b0, 8'b10, 32'h0, 0);
    @(negedge clk);
    chk("fp_wr_ce", 64'(fp_ce), 64'd1);
    chk("fp_wr_we", 64'(fp_mwe), 64'd1);
    chk("fp_wr_addr", 64'(fp_maddr), 64'h20);
    chk("fp_wr_wdata", 64'(fp_mwdata), 64'hDEADBEEF);
    chk("fp_wr_sel", 64'(fp_msel), 64'b0011);
    @(negedge clk);
    chk("fp_wr_we2", 64'(fp_mwe), 64'd1);
    @(negedge clk);
    chk("fp_wr_lat", 64'(fp_ack), 64'b10);
    fp_req = '0; fp_we = '0;
    @(negedge clk);
    chk("fp_idle_we", 64'(fp_mwe), 64'd0);
    chk("fp_idle_wdata", 64'(fp_mwdata), 64'd0);
    chk("fp_idle_sel", 64'(fp_msel), 64'd0);

    // contention: master 0 monopolises until it withdraws
    fp_addr[63:32] = 32'h24;
    base = fp_cnt;
    for (int i = 0; i < 4; i++) push(1'b0, 8'b01, mem_fn(32'h10), (i == 0) ? 0 : 4);
    push(1'b0, 8'b10, mem_fn(32'h24), 4);
    fp_req = 2'b11;
    wait_acks(1'b0, base + 4, "fp_cont_wait0");
    fp_req = 2'b10;
    wait_acks(1'b0, base + 5, "fp_cont_wait1");
    fp_req = '0;
    repeat (4) @(negedge clk);

    // request withdrawn in the first BUSY cycle still completes once
    base = fp_cnt;
    fp_req = 2'b01;
    push(1'b0, 8'b01, mem_fn(32'h10), 0);
    @(negedge clk);
    chk("fp_wd_ce", 64'(fp_ce), 64'd1);
    fp_req = '0;
    repeat (6) @(negedge clk);
    chk("fp_wd_count", 64'(fp_cnt - base), 64'd1);

    // reset mid-BUSY aborts; the held request is served afterwards
    fp_addr[31:0] = 32'h30;
    fp_req = 2'b01;
    push(1'b0, 8'b01, mem_fn(32'h30), 0);
    @(negedge clk);
    chk("fp_rb_ce", 64'(fp_ce), 64'd1);
    rst_fp = 1'b1;
    #1;
    chk("fp_rb_ce_off", 64'(fp_ce), 64'd0);
    chk("fp_rb_ack", 64'(fp_ack), 64'd0);
    chk("fp_rb_addr", 64'(fp_maddr), 64'd0);
    @(negedge clk);
    rst_fp = 1'b0;
    @(negedge clk);
    chk("fp_pr_ce1", 64'(fp_ce), 64'd1);
    @(negedge clk);
    chk("fp_pr_ce2", 64'(fp_ce), 64'd1);
    @(negedge clk);
    chk("fp_pr_lat", 64'(fp_ack), 64'b01);
    fp_req = '0;
    repeat (4) @(negedge clk);
    chk("fp_queue_empty", 64'(fp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
